fm_qarctan_demod: RTL and testbench

- FM discriminator stage. Takes a complex baseband stream (I/Q) and outputs the instantaneous phase difference between consecutive samples, using the quantized arctan approximation.
- Sits directly upstream of the sequential `div` block. It builds the dividend and divisor, issues one divide at a time, consumes the quotient, and produces the demodulated sample.
- Its output feeds the audio decimation/filter chain.

---
 rtl/fm_qarctan_demod.sv | 204 ++++++++++++++++++++
 tb/tb_fm_qarctan_demod.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fm_qarctan_demod.sv
// rtl/fm_qarctan_demod.sv - FM discriminator using quantized arctan with an external sequential divider
module fm_qarctan_demod #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int QUARTER_PI = 804
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    output logic                         div_valid_in,
    output logic signed [63:0]           div_dividend,
    output logic signed [31:0]           div_divisor,
    input  logic signed [63:0]           div_quotient,
    input  logic                         div_valid_out,
    input  logic                         div_overflow,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         err
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] QP1 = DATA_WIDTH'(QUARTER_PI);
    localparam logic signed [DATA_WIDTH-1:0] QP3 = DATA_WIDTH'(3 * QUARTER_PI);
    localparam logic signed [63:0]           QP64 = 64'(QUARTER_PI);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ISSUE,
        S_WAIT,
        S_SCALE,
        S_OUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [DATA_WIDTH-1:0] cur_r;
    logic signed [DATA_WIDTH-1:0] cur_i;
    logic signed [DATA_WIDTH-1:0] prev_r;
    logic signed [DATA_WIDTH-1:0] prev_i;
    logic signed [DATA_WIDTH-1:0] base;
    logic                         neg;
    logic signed [31:0]           q;

    // conjugate multiply of current by previous sample, each product dequantized separately
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ir;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] dot;
    logic signed [PW-1:0] crs;

    assign p_rr = $signed({{DATA_WIDTH{cur_r[DATA_WIDTH-1]}}, cur_r})
                * $signed({{DATA_WIDTH{prev_r[DATA_WIDTH-1]}}, prev_r});
    assign p_ii = $signed({{DATA_WIDTH{cur_i[DATA_WIDTH-1]}}, cur_i})
                * $signed({{DATA_WIDTH{prev_i[DATA_WIDTH-1]}}, prev_i});
    assign p_ir = $signed({{DATA_WIDTH{cur_i[DATA_WIDTH-1]}}, cur_i})
                * $signed({{DATA_WIDTH{prev_r[DATA_WIDTH-1]}}, prev_r});
    assign p_ri = $signed({{DATA_WIDTH{cur_r[DATA_WIDTH-1]}}, cur_r})
                * $signed({{DATA_WIDTH{prev_i[DATA_WIDTH-1]}}, prev_i});
    assign dot  = (p_rr >>> BITS) + (p_ii >>> BITS);
    assign crs  = (p_ir >>> BITS) - (p_ri >>> BITS);

    logic signed [DATA_WIDTH-1:0] r_c;
    logic signed [DATA_WIDTH-1:0] i_c;
    logic signed [DATA_WIDTH-1:0] abs_y;
    logic signed [DATA_WIDTH-1:0] num_c;
    logic signed [DATA_WIDTH-1:0] den_c;
    logic signed [DATA_WIDTH-1:0] base_c;

    assign r_c = dot[DATA_WIDTH-1:0];
    assign i_c = crs[DATA_WIDTH-1:0];
    // the +1 keeps the divisor nonzero even for a zero vector
    assign abs_y = (i_c[DATA_WIDTH-1] ? -i_c : i_c) + DATA_WIDTH'(1);

    // pick the octant-pair formula from the sign of the real part
    always_comb begin
        num_c  = r_c - abs_y;
        den_c  = r_c + abs_y;
        base_c = QP1;
        if (r_c[DATA_WIDTH-1]) begin
            num_c  = r_c + abs_y;
            den_c  = abs_y - r_c;
            base_c = QP3;
        end
    end

    // angle = base - (pi/4) * quotient, then mirrored for negative imaginary part
    logic signed [63:0]           prod;
    logic signed [63:0]           scaled;
    logic signed [DATA_WIDTH-1:0] a_c;

    assign prod   = QP64 * $signed({{32{q[31]}}, q});
    assign scaled = prod >>> BITS;
    assign a_c    = base - scaled[DATA_WIDTH-1:0];

    logic unused_bits;
    assign unused_bits = ^{div_quotient[63:32], dot[PW-1:DATA_WIDTH],
                           crs[PW-1:DATA_WIDTH], scaled[63:DATA_WIDTH]};

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and handshake outputs; one sample in flight at a time
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        div_valid_in = 1'b0;
        out_valid    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                div_valid_in = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (div_valid_out) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // datapath registers; the quotient is only taken while waiting so stale results are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_r        <= '0;
            cur_i        <= '0;
            prev_r       <= '0;
            prev_i       <= '0;
            base         <= '0;
            neg          <= 1'b0;
            q            <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            out_data     <= '0;
            err          <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        cur_r <= in_real;
                        cur_i <= in_imag;
                    end
                end
                S_PREP: begin
                    prev_r       <= cur_r;
                    prev_i       <= cur_i;
                    base         <= base_c;
                    neg          <= i_c[DATA_WIDTH-1];
                    div_dividend <= $signed({{(64-DATA_WIDTH){num_c[DATA_WIDTH-1]}}, num_c}) <<< BITS;
                    div_divisor  <= 32'(den_c);
                end
                S_WAIT: begin
                    if (div_valid_out) begin
                        if (div_overflow) begin
                            q   <= '0;
                            err <= 1'b1;
                        end else begin
                            q <= div_quotient[31:0];
                        end
                    end
                end
                S_SCALE: begin
                    out_data <= neg ? -a_c : a_c;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm_qarctan_demod.sv
// tb/tb_fm_qarctan_demod.sv - directed vectors for fm_qarctan_demod with a variable-latency divider model
module tb_fm_qarctan_demod;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_real = '0;
    logic signed [31:0] in_imag = '0;
    logic               div_valid_in;
    logic signed [63:0] div_dividend;
    logic signed [31:0] div_divisor;
    logic signed [63:0] div_quotient = '0;
    logic               div_valid_out = 1'b0;
    logic               div_overflow = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [31:0] out_data;
    logic               err;

    int vectors = 0;
    int miscompares = 0;

    int lat = 1;
    bit force_ovf = 1'b0;
    int pulses = 0;
    int cnt = 0;
    bit busy = 1'b0;
    logic signed [63:0] cap_dividend = '0;
    logic signed [31:0] cap_divisor = '0;
    logic signed [63:0] dsr;

    fm_qarctan_demod #(
        .DATA_WIDTH(32),
        .BITS(10),
        .QUARTER_PI(804)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_real(in_real),
        .in_imag(in_imag),
        .div_valid_in(div_valid_in),
        .div_dividend(div_dividend),
        .div_divisor(div_divisor),
        .div_quotient(div_quotient),
        .div_valid_out(div_valid_out),
        .div_overflow(div_overflow),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .err(err)
    );

    always #5 clock = ~clock;

    // signed divider truncating toward zero, result after lat cycles
    always @(negedge clock) begin
        if (div_valid_in) begin
            cap_dividend  = div_dividend;
            cap_divisor   = div_divisor;
            pulses        = pulses + 1;
            cnt           = lat;
            busy          = 1'b1;
            div_valid_out = 1'b0;
            div_overflow  = 1'b0;
        end else if (busy) begin
            cnt = cnt - 1;
            if (cnt <= 0) begin
                dsr           = {{32{cap_divisor[31]}}, cap_divisor};
                div_quotient  = force_ovf ? 64'sh7fff_ffff_1234_5678 : cap_dividend / dsr;
                div_overflow  = force_ovf;
                div_valid_out = 1'b1;
                busy          = 1'b0;
            end else begin
                div_valid_out = 1'b0;
                div_overflow  = 1'b0;
            end
        end else begin
            div_valid_out = 1'b0;
            div_overflow  = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_sample(input string tag, input int r, input int i, input int lt,
                              input logic signed [63:0] e_dvd, input logic signed [63:0] e_dvs,
                              input int e_out);
        int p0;
        int n;
        lat = lt;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        p0 = pulses;
        in_real  = r;
        in_imag  = i;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_dividend"}, cap_dividend, e_dvd);
        chk({tag, "_divisor"}, cap_divisor, e_dvs);
        chk({tag, "_out_data"}, out_data, e_out);
        chk({tag, "_div_pulses"}, pulses - p0, 1);
        if (out_ready) begin
            @(negedge clock);
            chk({tag, "_out_drop"}, out_valid, 0);
        end
    endtask

    initial begin
        int p0;
        bit saw;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_valid_in", div_valid_in, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);
        chk("rst_err", err, 0);

        run_sample("s1_first", 1024, 0, 3, -1024, 1, 1608);
        chk("s1_err", err, 0);
        run_sample("s2_same", 1024, 0, 1, 1047552, 1025, 2);
        run_sample("s3_plus90", 0, 1024, 7, -1049600, 1025, 1608);
        run_sample("s4_r_neg", 0, -1024, 40, -1047552, 1025, 3215);
        run_sample("s5_back", 1024, 0, 2, -1049600, 1025, 1608);
        run_sample("s6_minus90", 0, -1024, 12, -1049600, 1025, -1608);
        run_sample("s7_back", 1024, 0, 25, -1049600, 1025, 1608);

        out_ready = 1'b0;
        run_sample("s8_stall", -1024, 0, 5, -1047552, 1025, 3215);
        p0 = pulses;
        in_real  = 5000;
        in_imag  = 5000;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, 3215);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("stall_release", out_valid, 0);
        chk("stall_no_issue", pulses - p0, 0);
        run_sample("s9_after_stall", -1024, 0, 9, 1047552, 1025, 2);

        force_ovf = 1'b1;
        run_sample("o1_ovf_pos", 0, -1024, 4, -1049600, 1025, 804);
        chk("o1_err", err, 1);
        run_sample("o2_ovf_neg", -1024, 0, 6, -1049600, 1025, -804);
        run_sample("o3_ovf_rneg", 1024, 0, 3, -1047552, 1025, 2412);
        force_ovf = 1'b0;
        run_sample("n1_sticky", 1024, 0, 2, 1047552, 1025, 2);
        chk("n1_err_sticky", err, 1);

        lat = 20;
        in_real  = 1024;
        in_imag  = 0;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_err", err, 0);
        chk("midrst_out_data", out_data, 0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) saw = 1'b1;
        end
        chk("midrst_late_result", saw, 0);
        run_sample("post_rst_prev0", 1024, 0, 2, -1024, 1, 1608);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
